// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - mdu_op_e    : 4-bit operation codes presented on mdu_ctrl.op
//   - mdu_state_e : controller FSM state encoding (also seen on dbg_state)
//   - DIV_ITERS   : restoring-division iteration count (one quotient bit each)
//   - mdu_dec_t / mdu_decode : op-code decode into control flags
//   - mdu_mag     : magnitude of a 32-bit operand (signed or unsigned view)
// Optional feature macro: MDU_ACCUM_EN (enables MADD/MADDU/MSUB/MSUBU decode).
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_WB   = 2'd3
  } mdu_state_e;

  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = $clog2(DIV_ITERS);

  typedef struct packed {
    logic is_mul;     // goes through the multiplier pipeline
    logic is_div;     // goes through the iterative divider
    logic is_mthi;
    logic is_mtlo;
    logic is_signed;  // operands are two's complement
    logic is_accum;   // product is combined with current HI/LO
    logic is_sub;     // accumulate by subtraction
  } mdu_dec_t;

  // Codes not listed (and the accumulate codes when MDU_ACCUM_EN is not
  // defined) decode to all-zero flags, i.e. a no-op.
  function automatic mdu_dec_t mdu_decode(input logic [3:0] op);
    mdu_dec_t d;
    d = '0;
    case (op)
      OP_MULT:  begin d.is_mul = 1'b1; d.is_signed = 1'b1; end
      OP_MULTU: begin d.is_mul = 1'b1; end
      OP_DIV:   begin d.is_div = 1'b1; d.is_signed = 1'b1; end
      OP_DIVU:  begin d.is_div = 1'b1; end
      OP_MTHI:  begin d.is_mthi = 1'b1; end
      OP_MTLO:  begin d.is_mtlo = 1'b1; end
`ifdef MDU_ACCUM_EN
      OP_MADD:  begin d.is_mul = 1'b1; d.is_signed = 1'b1; d.is_accum = 1'b1; end
      OP_MADDU: begin d.is_mul = 1'b1; d.is_accum = 1'b1; end
      OP_MSUB:  begin d.is_mul = 1'b1; d.is_signed = 1'b1; d.is_accum = 1'b1; d.is_sub = 1'b1; end
      OP_MSUBU: begin d.is_mul = 1'b1; d.is_accum = 1'b1; d.is_sub = 1'b1; end
`endif
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] mdu_mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: iterative restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst       clock / synchronous active-high reset
//   start          load operands and begin (single-cycle pulse)
//   abort          drop the running division
//   is_signed      treat dividend/divisor as two's complement
//   dividend       numerator (32)
//   divisor        denominator (32)
//   done           high during the final iteration cycle; quotient and
//                  remainder are final from the following cycle on
//   quotient       signed-corrected quotient (32)
//   remainder      signed-corrected remainder (32)
// Divide by zero yields quotient all-ones and remainder = raw dividend.
module mdu_div_core
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic                 running_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [31:0]          quo_q;      // dividend bits shift out, quotient bits shift in
  logic [31:0]          rem_q;
  logic [31:0]          den_q;      // divisor magnitude
  logic [31:0]          num_raw_q;  // untouched dividend, for divide-by-zero
  logic                 q_neg_q;
  logic                 r_neg_q;
  logic                 div_zero_q;

  logic [32:0] shifted;
  logic [32:0] diff;

  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, den_q};
  end

  assign done = running_q && (cnt_q == DIV_CNT_W'(DIV_ITERS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      running_q  <= 1'b0;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      den_q      <= '0;
      num_raw_q  <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (abort) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
    end else if (start) begin
      running_q  <= 1'b1;
      cnt_q      <= '0;
      quo_q      <= mdu_mag(dividend, is_signed);
      rem_q      <= '0;
      den_q      <= mdu_mag(divisor, is_signed);
      num_raw_q  <= dividend;
      q_neg_q    <= is_signed && (dividend[31] ^ divisor[31]);
      r_neg_q    <= is_signed && dividend[31];
      div_zero_q <= (divisor == 32'd0);
    end else if (running_q) begin
      // Restore-by-not-committing: keep the shifted remainder when the trial
      // subtraction goes negative.
      if (!diff[32]) begin
        rem_q <= diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= shifted[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
      cnt_q <= cnt_q + 1'b1;
      if (done) running_q <= 1'b0;
    end
  end

  // 0x80000000 / -1 needs no special case: the magnitude quotient is
  // 0x80000000, signs agree, so it passes through unnegated with remainder 0.
  assign quotient  = div_zero_q ? 32'hFFFF_FFFF :
                     (q_neg_q ? (32'd0 - quo_q) : quo_q);
  assign remainder = div_zero_q ? num_raw_q :
                     (r_neg_q ? (32'd0 - rem_q) : rem_q);

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller with HI/LO write-back.
// Ports:
//   clk, rst               clock / synchronous active-high reset
//   op_valid, op           request from EX stage, 4-bit op code (mdu_pkg)
//   rs_data, rt_data       operands, latched when the request is accepted
//   flush                  abort an in-flight MUL/DIV (ignored in WB)
//   hi_in, lo_in           current HI/LO contents (accumulate ops, read in WB)
//   op_ready               = !busy
//   busy                   stall request, high from acceptance+1 through WB
//   to_hi, to_lo           one-cycle HI/LO write strobes
//   to_hi_data, to_lo_data write data (zero when no strobe)
//   done                   one-cycle pulse with the final write of MUL/DIV
//   dbg_state              current FSM state (mdu_state_e encoding)
// Handshake: a request is taken on a rising edge where op_valid && op_ready
// && !flush; there is no queueing, so op_valid while busy is simply dropped.
// Optional feature macro: MDU_ACCUM_EN (MADD/MADDU/MSUB/MSUBU).
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic        op_ready,
  output logic        busy,
  output logic        to_hi,
  output logic        to_lo,
  output logic [31:0] to_hi_data,
  output logic [31:0] to_lo_data,
  output logic        done,
  output logic [1:0]  dbg_state
);

  mdu_state_e  state_q, state_d;
  mdu_dec_t    dec;
  logic        accept;

  logic        op_div_q;
  logic        op_signed_q;
  logic        op_accum_q;
  logic        op_sub_q;
  logic [31:0] a_q, b_q;
  logic [2:0]  mul_cnt_q;

  logic        mt_hi_q, mt_lo_q;
  logic [31:0] mt_data_q;

  logic [63:0] mul_ext_a, mul_ext_b, prod_comb;
  logic [63:0] mul_pipe_q [MUL_STAGES];
  logic [63:0] acc_base, mul_res;

  logic        div_start, div_abort, div_done;
  logic [31:0] div_quo, div_rem;

  assign dec       = mdu_decode(op);
  assign busy      = (state_q != ST_IDLE);
  assign op_ready  = !busy;
  assign accept    = op_valid && op_ready && !flush;
  assign dbg_state = state_q;

  // ---------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_div_q    <= 1'b0;
      op_signed_q <= 1'b0;
      op_accum_q  <= 1'b0;
      op_sub_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      mul_cnt_q   <= '0;
      mt_hi_q     <= 1'b0;
      mt_lo_q     <= 1'b0;
      mt_data_q   <= '0;
    end else begin
      state_q <= state_d;
      mt_hi_q <= accept && dec.is_mthi;
      mt_lo_q <= accept && dec.is_mtlo;
      if (accept && (dec.is_mthi || dec.is_mtlo)) mt_data_q <= rs_data;
      if (accept && (dec.is_mul || dec.is_div)) begin
        op_div_q    <= dec.is_div;
        op_signed_q <= dec.is_signed;
        op_accum_q  <= dec.is_accum;
        op_sub_q    <= dec.is_sub;
        a_q         <= rs_data;
        b_q         <= rt_data;
      end
      mul_cnt_q <= (state_q == ST_MUL) ? (mul_cnt_q + 3'd1) : 3'd0;
    end
  end

  // ---------------------------------------------------------------------
  // Multiplier: full 64-bit product from the latched operands, then
  // MUL_STAGES register stages. The last stage lands exactly in WB.
  // ---------------------------------------------------------------------
  always_comb begin
    mul_ext_a = op_signed_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    mul_ext_b = op_signed_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod_comb = mul_ext_a * mul_ext_b;
  end

  always_ff @(posedge clk) begin
    mul_pipe_q[0] <= prod_comb;
    for (int i = 1; i < MUL_STAGES; i++) begin
      mul_pipe_q[i] <= mul_pipe_q[i-1];
    end
  end

  // ---------------------------------------------------------------------
  // Divider
  // ---------------------------------------------------------------------
  assign div_start = accept && dec.is_div;
  assign div_abort = flush && (state_q == ST_DIV);

  mdu_div_core u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (div_abort),
    .is_signed (dec.is_signed),
    .dividend  (rs_data),
    .divisor   (rt_data),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // ---------------------------------------------------------------------
  // Next state and write-back outputs. HI/LO are read combinationally in
  // WB so accumulate ops see the register contents of that very cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    to_hi      = 1'b0;
    to_lo      = 1'b0;
    done       = 1'b0;
    to_hi_data = '0;
    to_lo_data = '0;
    acc_base   = op_accum_q ? {hi_in, lo_in} : 64'd0;
    mul_res    = op_sub_q ? (acc_base - mul_pipe_q[MUL_STAGES-1])
                          : (acc_base + mul_pipe_q[MUL_STAGES-1]);

    case (state_q)
      ST_IDLE: begin
        if (accept && dec.is_mul)      state_d = ST_MUL;
        else if (accept && dec.is_div) state_d = ST_DIV;
      end
      ST_MUL: begin
        if (flush)                                   state_d = ST_IDLE;
        else if (mul_cnt_q == 3'(MUL_STAGES - 1))    state_d = ST_WB;
      end
      ST_DIV: begin
        if (flush)         state_d = ST_IDLE;
        else if (div_done) state_d = ST_WB;
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q == ST_WB) begin
      to_hi = 1'b1;
      to_lo = 1'b1;
      done  = 1'b1;
      if (op_div_q) {to_hi_data, to_lo_data} = {div_rem, div_quo};
      else          {to_hi_data, to_lo_data} = mul_res;
    end else begin
      // MTHI/MTLO are only accepted in IDLE, so they never overlap WB.
      to_hi      = mt_hi_q;
      to_lo      = mt_lo_q;
      to_hi_data = mt_hi_q ? mt_data_q : 32'd0;
      to_lo_data = mt_lo_q ? mt_data_q : 32'd0;
    end
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MUL_STAGES, default 2, multiplier pipeline depth in cycles (1..4).
REQ-002 SHALL have ports: clk  in  1  clock, all logic on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: op_valid  in  1  request from EX stage.
REQ-005 SHALL have port: op  in  4  operation code (mdu_pkg).
REQ-006 SHALL have ports: rs_data, rt_data  in  32  operands.
REQ-007 SHALL have port: flush  in  1  abort in-flight operation.
REQ-008 SHALL have ports: hi_in, lo_in  in  32  current HI/LO register contents.
REQ-009 SHALL have port: op_ready  out  1  equals !busy; request accepted only when high.
REQ-010 SHALL have port: busy  out  1  pipeline stall request.
REQ-011 SHALL have ports: to_hi, to_lo  out  1  one-cycle write strobes to HI/LO register.
REQ-012 SHALL have ports: to_hi_data, to_lo_data  out  32  write data.
REQ-013 SHALL have port: done  out  1  one-cycle pulse coincident with the final write of a MUL/DIV op.

Function
REQ-014 SHALL accept an op at cycle T when op_valid && op_ready && !flush.
REQ-015 SHALL implement states IDLE, MUL, DIV, WB: MULT/MULTU -> MUL; DIV/DIVU -> DIV; MUL after MUL_STAGES cycles -> WB; DIV after 32 iterations -> WB; WB -> IDLE.
REQ-016 SHALL assert busy from T+1 through the WB cycle inclusive; op_ready low over the same span.
REQ-017 SHALL, for MTHI/MTLO, pulse to_hi (resp. to_lo) with rs_data at T+1, without busy or done.
REQ-018 SHALL, for MULT (signed) / MULTU, write {hi,lo} = 64-bit product at cycle T+MUL_STAGES+1.
REQ-019 SHALL, for DIV/DIVU, use restoring division at 1 quotient bit per cycle on magnitudes; write at T+33: lo = quotient, hi = remainder.
REQ-020 SHALL negate the signed quotient when operand signs differ; remainder takes the sign of the dividend.
REQ-021 SHALL, on divide by zero, write lo = 0xFFFFFFFF, hi = rs_data.
REQ-022 SHALL, on signed 0x80000000 / 0xFFFFFFFF, write lo = 0x80000000, hi = 0.
REQ-023 SHALL latch operands at acceptance; later changes to rs_data/rt_data have no effect.
REQ-024 SHALL, on flush in MUL or DIV, return to IDLE next cycle with no write and no done.
REQ-025 SHALL ignore flush in WB; the write completes.
REQ-026 SHALL ignore op_valid while busy; no queueing.
REQ-027 SHALL treat undefined op codes as no-ops: no write, no busy.

Reset
REQ-028 SHALL, on rst, enter IDLE and clear busy, done, to_hi, to_lo, to_hi_data, to_lo_data to 0 on the next edge.
REQ-029 SHALL, on rst mid-operation, discard the operation without any write.

Configuration
REQ-030 SHALL, with MDU_ACCUM_EN defined, support MADD/MADDU/MSUB/MSUBU: result {hi,lo} = {hi_in,lo_in} +/- product; hi_in and lo_in are sampled in the WB cycle; same latency as MULT.
REQ-031 SHALL, without MDU_ACCUM_EN, treat those codes as undefined ops per REQ-027.

Structure
REQ-032 SHALL take op codes, state encodings and the division iteration count (32) from shared package mdu_pkg.
REQ-033 SHALL place the iterative divider datapath in sub-module mdu_div_core (start, signed, operands -> done, quotient, remainder); the FSM and the multiplier pipeline remain in mdu_ctrl.

Verification
REQ-034 SHALL cover MULT 0xFFFFFFFE x 0x00000003 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFFA at T+3 (MUL_STAGES = 2); MULTU with the same operands -> hi = 0x00000002, lo = 0xFFFFFFFA.
REQ-035 SHALL cover DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF at T+33; busy high for cycles T+1..T+33.
REQ-036 SHALL cover DIVU 100 / 0 -> lo = 0xFFFFFFFF, hi = 100; DIV 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
REQ-037 SHALL cover flush at T+10 of a DIV -> no to_hi/to_lo, op_ready high by T+11; a new MULT accepted at T+11 completes normally.
REQ-038 SHALL cover MTLO 0x1234 -> to_lo pulse at T+1 with data 0x1234 and busy never asserted; op_valid during busy is ignored.
REQ-039 SHALL cover, with MDU_ACCUM_EN defined, MADD 2 x 3 with hi_in = 0, lo_in = 0xFFFFFFFF -> hi = 1, lo = 5; without the macro, no write occurs.
